instruction_decode: RTL and testbench

//  ID stage of the 5-stage MIPS pipeline; consumes instruction/PC from instructionFetch.

---
 rtl/instruction_decode_pkg.sv | 93 +++++++++
 rtl/instruction_decode_register_file.sv | 33 +++
 rtl/instruction_decode.sv | 130 +++++++++++++
 tb/tb_instruction_decode.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_decode_pkg.sv
// Shared decode definitions for the ID stage: opcodes, functs, ALU control
// encodings, the NOP word and the decoded-control bundle.
package instruction_decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctl_t;

    typedef struct packed {
        logic     reg_write;
        logic     mem_to_reg;
        logic     mem_write;
        logic     alu_src;
        logic     reg_dst;
        alu_ctl_t alu_ctl;
        logic     branch_eq;
        logic     branch_ne;
        logic     jump;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // Main decoder: anything not recognised (including the all-zero NOP) yields no control.
    function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] funct);
        ctrl_t c;
        c = CTRL_NONE;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: c.alu_ctl = ALU_ADD;
                    FUNCT_SUB: c.alu_ctl = ALU_SUB;
                    FUNCT_AND: c.alu_ctl = ALU_AND;
                    FUNCT_OR:  c.alu_ctl = ALU_OR;
                    FUNCT_SLT: c.alu_ctl = ALU_SLT;
                    default:   ;
                endcase
                if (funct == FUNCT_ADD || funct == FUNCT_SUB || funct == FUNCT_AND ||
                    funct == FUNCT_OR  || funct == FUNCT_SLT) begin
                    c.reg_write = 1'b1;
                    c.reg_dst   = 1'b1;
                end
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_src    = 1'b1;
                c.alu_ctl    = ALU_ADD;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_ctl   = ALU_ADD;
            end
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_ctl   = ALU_ADD;
            end
            OP_BEQ: begin
                c.branch_eq = 1'b1;
                c.alu_ctl   = ALU_SUB;
            end
            OP_BNE: begin
                c.branch_ne = 1'b1;
                c.alu_ctl   = ALU_SUB;
            end
            OP_J:    c.jump = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32-entry register file, two combinational read ports with write-through
// bypass, one write port; r0 is hard-wired to zero.
module instruction_decode_register_file #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] ra1,
    input  logic [REG_ADDR_W-1:0] ra2,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0]     wd,
    output logic [DATA_W-1:0]     rd1,
    output logic [DATA_W-1:0]     rd2
);

    logic [DATA_W-1:0] mem [2**REG_ADDR_W];

    // Storage update: clear everything on reset, ignore writes to r0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**REG_ADDR_W; i++) mem[i] <= '0;
        end else if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    // A write landing this cycle is visible to the read in the same cycle.
    assign rd1 = (ra1 == '0) ? '0 : (we && wa == ra1) ? wd : mem[ra1];
    assign rd2 = (ra2 == '0) ? '0 : (we && wa == ra2) ? wd : mem[ra2];

endmodule

// File: rtl/instruction_decode.sv
// ID stage: IF/ID register, decode, register file access, branch/jump
// resolution with MEM forwarding, hazard detection and the ID/EX register.
module instruction_decode
    import instruction_decode_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     PCF,
    input  logic [DATA_W-1:0]     instructionF,
    input  logic                  RegWriteW,
    input  logic [REG_ADDR_W-1:0] WriteRegW,
    input  logic [DATA_W-1:0]     ResultW,
    input  logic                  RegWriteM,
    input  logic                  MemtoRegM,
    input  logic [REG_ADDR_W-1:0] WriteRegM,
    input  logic [DATA_W-1:0]     ALUOutM,
    output logic                  PCSrcD,
    output logic [DATA_W-1:0]     PCbranchD,
    output logic                  hazardDetected,
    output logic                  RegWriteE,
    output logic                  MemtoRegE,
    output logic                  MemWriteE,
    output logic                  ALUSrcE,
    output logic                  RegDstE,
    output logic [2:0]            ALUControlE,
    output logic [DATA_W-1:0]     RD1E,
    output logic [DATA_W-1:0]     RD2E,
    output logic [DATA_W-1:0]     SignImmE,
    output logic [REG_ADDR_W-1:0] RsE,
    output logic [REG_ADDR_W-1:0] RtE,
    output logic [REG_ADDR_W-1:0] RdE
);

    logic [DATA_W-1:0]        instr_d;
    logic [DATA_W-1:0]        pc_plus4_d;
    logic [REG_ADDR_W-1:0]    rs_d, rt_d, rd_d;
    logic signed [DATA_W-1:0] sign_imm_d;
    ctrl_t                    ctrl_d;
    logic [DATA_W-1:0]        rd1_d, rd2_d, cmp_a, cmp_b;
    logic [DATA_W-1:0]        branch_target, jump_target;
    logic [REG_ADDR_W-1:0]    write_reg_e;
    logic                     take_d, lw_stall, branch_stall, e_hit, m_hit;

    // IF/ID: stall holds, a taken branch squashes the fetched instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_d    <= '0;
            pc_plus4_d <= '0;
        end else if (!hazardDetected) begin
            instr_d    <= PCSrcD ? NOP_INSTR : instructionF;
            pc_plus4_d <= PCF + DATA_W'(4);
        end
    end

    assign rs_d       = instr_d[25:21];
    assign rt_d       = instr_d[20:16];
    assign rd_d       = instr_d[15:11];
    assign sign_imm_d = DATA_W'(signed'(instr_d[15:0]));
    assign ctrl_d     = decode_ctrl(instr_d[31:26], instr_d[5:0]);

    instruction_decode_register_file #(
        .DATA_W    (DATA_W),
        .REG_ADDR_W(REG_ADDR_W)
    ) u_register_file (
        .clk  (clk),
        .rst_n(rst_n),
        .ra1  (rs_d),
        .ra2  (rt_d),
        .we   (RegWriteW),
        .wa   (WriteRegW),
        .wd   (ResultW),
        .rd1  (rd1_d),
        .rd2  (rd2_d)
    );

    // Branch comparison sees the MEM-stage ALU result before it reaches the register file.
    assign cmp_a  = (rs_d != '0 && RegWriteM && rs_d == WriteRegM) ? ALUOutM : rd1_d;
    assign cmp_b  = (rt_d != '0 && RegWriteM && rt_d == WriteRegM) ? ALUOutM : rd2_d;
    assign take_d = (ctrl_d.branch_eq && (cmp_a == cmp_b)) ||
                    (ctrl_d.branch_ne && (cmp_a != cmp_b)) || ctrl_d.jump;

    assign branch_target = pc_plus4_d + $unsigned(sign_imm_d <<< 2);
    assign jump_target   = {pc_plus4_d[DATA_W-1:DATA_W-4], instr_d[25:0], 2'b00};
    assign PCbranchD     = ctrl_d.jump ? jump_target : branch_target;

    // Load-use and branch-operand-not-ready stalls; r0 never creates a dependency.
    assign write_reg_e  = RegDstE ? RdE : RtE;
    assign lw_stall     = MemtoRegE && RtE != '0 && (RtE == rs_d || RtE == rt_d);
    assign e_hit        = RegWriteE && write_reg_e != '0 && (write_reg_e == rs_d || write_reg_e == rt_d);
    assign m_hit        = MemtoRegM && WriteRegM != '0 && (WriteRegM == rs_d || WriteRegM == rt_d);
    assign branch_stall = (ctrl_d.branch_eq || ctrl_d.branch_ne) && (e_hit || m_hit);

    assign hazardDetected = lw_stall || branch_stall;
    assign PCSrcD         = take_d && !hazardDetected;

    // ID/EX: a stall inserts an all-zero bubble; reset also empties the stage.
    always_ff @(posedge clk) begin
        if (!rst_n || hazardDetected) begin
            RegWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            MemWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            RegDstE     <= 1'b0;
            ALUControlE <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            SignImmE    <= '0;
            RsE         <= '0;
            RtE         <= '0;
            RdE         <= '0;
        end else begin
            RegWriteE   <= ctrl_d.reg_write;
            MemtoRegE   <= ctrl_d.mem_to_reg;
            MemWriteE   <= ctrl_d.mem_write;
            ALUSrcE     <= ctrl_d.alu_src;
            RegDstE     <= ctrl_d.reg_dst;
            ALUControlE <= ctrl_d.alu_ctl;
            RD1E        <= rd1_d;
            RD2E        <= rd2_d;
            SignImmE    <= $unsigned(sign_imm_d);
            RsE         <= rs_d;
            RtE         <= rt_d;
            RdE         <= rd_d;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for the ID stage: directed scenarios followed by random traffic,
// every cycle compared against an instruction-level reference model.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PCF, instructionF;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic        RegWriteM, MemtoRegM;
    logic [4:0]  WriteRegM;
    logic [31:0] ALUOutM;
    logic        PCSrcD, hazardDetected;
    logic [31:0] PCbranchD;
    logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, SignImmE;
    logic [4:0]  RsE, RtE, RdE;

    always #5 clk = ~clk;

    instruction_decode dut (
        .clk(clk), .rst_n(rst_n), .PCF(PCF), .instructionF(instructionF),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM), .ALUOutM(ALUOutM),
        .PCSrcD(PCSrcD), .PCbranchD(PCbranchD), .hazardDetected(hazardDetected),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .RsE(RsE), .RtE(RtE), .RdE(RdE)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state: architectural registers, the instruction sitting
    // in decode with its PC+4, and what execute was handed last.
    logic [31:0] mregs [32];
    logic [31:0] m_instr, m_pc4;
    logic [7:0]  e_ctl;
    logic [31:0] e_rd1, e_rd2, e_imm;
    logic [4:0]  e_rs, e_rt, e_rd;
    logic        exp_haz, exp_pcsrc;
    logic [31:0] exp_target;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Meaning of each instruction: {RegWrite,MemtoReg,MemWrite,ALUSrc,RegDst,ALUControl,beq,bne,j}.
    function automatic logic [10:0] ref_ctrl(input logic [31:0] ins);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'h00) begin
            if (fn == 6'h20) return 11'b10001_010_000;
            if (fn == 6'h22) return 11'b10001_110_000;
            if (fn == 6'h24) return 11'b10001_000_000;
            if (fn == 6'h25) return 11'b10001_001_000;
            if (fn == 6'h2A) return 11'b10001_111_000;
            return '0;
        end
        if (op == 6'h23) return 11'b11010_010_000;
        if (op == 6'h2B) return 11'b00110_010_000;
        if (op == 6'h08) return 11'b10010_010_000;
        if (op == 6'h04) return 11'b00000_110_100;
        if (op == 6'h05) return 11'b00000_110_010;
        if (op == 6'h02) return 11'b00000_000_001;
        return '0;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (RegWriteW && WriteRegW == a) return ResultW;
        return mregs[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        m_instr = 0; m_pc4 = 0;
        e_ctl = 0; e_rd1 = 0; e_rd2 = 0; e_imm = 0; e_rs = 0; e_rt = 0; e_rd = 0;
    endtask

    task automatic model_eval();
        logic [10:0] c;
        logic [4:0]  rs, rt, wre;
        logic [31:0] a, b, imm;
        logic        lw, bs;
        c   = ref_ctrl(m_instr);
        rs  = m_instr[25:21];
        rt  = m_instr[20:16];
        a   = (rs != 0 && RegWriteM && WriteRegM == rs) ? ALUOutM : ref_read(rs);
        b   = (rt != 0 && RegWriteM && WriteRegM == rt) ? ALUOutM : ref_read(rt);
        wre = e_ctl[3] ? e_rd : e_rt;
        lw  = e_ctl[6] && e_rt != 0 && (e_rt == rs || e_rt == rt);
        bs  = (c[2] || c[1]) &&
              ((e_ctl[7] && wre != 0 && (wre == rs || wre == rt)) ||
               (MemtoRegM && WriteRegM != 0 && (WriteRegM == rs || WriteRegM == rt)));
        exp_haz    = lw || bs;
        exp_pcsrc  = ((c[2] && a == b) || (c[1] && a != b) || c[0]) && !exp_haz;
        imm        = {{16{m_instr[15]}}, m_instr[15:0]};
        exp_target = c[0] ? {m_pc4[31:28], m_instr[25:0], 2'b00} : m_pc4 + imm * 32'd4;
    endtask

    task automatic model_tick();
        logic [10:0] c;
        if (!rst_n) begin
            model_clear();
            return;
        end
        c = ref_ctrl(m_instr);
        if (exp_haz) begin
            e_ctl = 0; e_rd1 = 0; e_rd2 = 0; e_imm = 0; e_rs = 0; e_rt = 0; e_rd = 0;
        end else begin
            e_ctl = c[10:3];
            e_rd1 = ref_read(m_instr[25:21]);
            e_rd2 = ref_read(m_instr[20:16]);
            e_imm = {{16{m_instr[15]}}, m_instr[15:0]};
            e_rs  = m_instr[25:21];
            e_rt  = m_instr[20:16];
            e_rd  = m_instr[15:11];
        end
        if (RegWriteW && WriteRegW != 0) mregs[WriteRegW] = ResultW;
        if (!exp_haz) begin
            if (exp_pcsrc) m_instr = 0;
            else begin
                m_instr = instructionF;
                m_pc4   = PCF + 32'd4;
            end
        end
    endtask

    task automatic settle();
        #4;
        model_eval();
        chk("hazardDetected", 32'(hazardDetected), 32'(exp_haz));
        chk("PCSrcD", 32'(PCSrcD), 32'(exp_pcsrc));
        if (exp_pcsrc) chk("PCbranchD", PCbranchD, exp_target);
        chk("ctrlE", 32'({RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE}), 32'(e_ctl));
        chk("RD1E", RD1E, e_rd1);
        chk("RD2E", RD2E, e_rd2);
        chk("SignImmE", SignImmE, e_imm);
        chk("regidxE", 32'({RsE, RtE, RdE}), 32'({e_rs, e_rt, e_rd}));
    endtask

    task automatic tick();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic quiet();
        RegWriteW = 0; WriteRegW = 0; ResultW = 0;
        RegWriteM = 0; MemtoRegM = 0; WriteRegM = 0; ALUOutM = 0;
    endtask

    task automatic fetch(input logic [31:0] ins, input logic [31:0] pc);
        instructionF = ins;
        PCF          = pc;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        case ($urandom_range(0, 12))
            0:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};
            1:  return {6'h00, rs, rt, rd, 5'd0, 6'h22};
            2:  return {6'h00, rs, rt, rd, 5'd0, 6'h24};
            3:  return {6'h00, rs, rt, rd, 5'd0, 6'h25};
            4:  return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
            5:  return {6'h23, rs, rt, imm};
            6:  return {6'h2B, rs, rt, imm};
            7:  return {6'h08, rs, rt, imm};
            8:  return {6'h04, rs, rt, imm};
            9:  return {6'h05, rs, rt, imm};
            10: return {6'h02, 26'($urandom)};
            11: return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        quiet();
        fetch(32'd0, 32'd0);
        @(posedge clk);
        #1;
        model_clear();

        // Reset held two cycles: everything downstream reads zero.
        step();
        step();
        settle();
        chk("rst_haz", 32'(hazardDetected), 32'd0);
        chk("rst_pcsrc", 32'(PCSrcD), 32'd0);
        chk("rst_target", PCbranchD, 32'd0);
        chk("rst_ctrlE", 32'({RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE}), 32'd0);
        chk("rst_rd1", RD1E, 32'd0);
        tick();
        rst_n = 1'b1;

        // addi $1,$0,5 ; add $3,$1,$1 with write-back of $1=5 in the same cycle.
        fetch(32'h2001_0005, 32'h0); step();
        fetch(32'h0021_1820, 32'h4); step();
        fetch(32'h0, 32'h8);
        RegWriteW = 1; WriteRegW = 5'd1; ResultW = 32'd5;
        step();
        quiet();
        settle();
        chk("bypass_rd1", RD1E, 32'd5);
        chk("bypass_rd2", RD2E, 32'd5);
        chk("bypass_rd", 32'(RdE), 32'd3);
        tick();

        // lw $2,0($0) followed by add $4,$2,$2: one stall cycle then the add proceeds.
        fetch(32'h8C02_0000, 32'hC); step();
        fetch(32'h0042_2020, 32'h10); step();
        fetch(32'h0, 32'h14);
        settle();
        chk("lw_stall", 32'(hazardDetected), 32'd1);
        tick();
        settle();
        chk("lw_release", 32'(hazardDetected), 32'd0);
        chk("lw_bubble", 32'({RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE}), 32'd0);
        tick();
        settle();
        chk("lw_add_rd", 32'(RdE), 32'd4);
        chk("lw_add_ctrl", 32'({RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE}), 32'b1000_1010);
        tick();

        // beq $1,$1,+3 at PC 0x10: taken to 0x20, following fetch squashed.
        fetch(32'h1021_0003, 32'h10); step();
        fetch(32'h2005_0007, 32'h14);
        settle();
        chk("beq_pcsrc", 32'(PCSrcD), 32'd1);
        chk("beq_target", PCbranchD, 32'h20);
        tick();
        settle();
        chk("beq_aluE", 32'(ALUControlE), 32'b110);
        tick();
        settle();
        chk("beq_squash", 32'(RegWriteE), 32'd0);
        tick();

        // $3=5 equals $1=5, but MEM forwards 9 for $3: bne is taken.
        fetch(32'h0, 32'h18);
        RegWriteW = 1; WriteRegW = 5'd3; ResultW = 32'd5;
        step();
        quiet();
        fetch(32'h1461_0002, 32'h40); step();
        fetch(32'h0, 32'h44);
        RegWriteM = 1; WriteRegM = 5'd3; ALUOutM = 32'd9;
        settle();
        chk("bne_pcsrc", 32'(PCSrcD), 32'd1);
        chk("bne_target", PCbranchD, 32'h4C);
        tick();
        quiet();

        // j 0x40 at PC 0x8, then an attempted write to r0.
        fetch(32'h0800_0040, 32'h8); step();
        fetch(32'h0, 32'hC);
        settle();
        chk("j_pcsrc", 32'(PCSrcD), 32'd1);
        chk("j_target", PCbranchD, 32'h100);
        tick();
        fetch(32'h0000_2820, 32'h100); step();
        fetch(32'h0, 32'h104);
        RegWriteW = 1; WriteRegW = 5'd0; ResultW = 32'hDEAD_BEEF;
        step();
        quiet();
        settle();
        chk("r0_rd1", RD1E, 32'd0);
        chk("r0_rd2", RD2E, 32'd0);
        tick();

        // Reset asserted while a load-use stall is active.
        fetch(32'h8C02_0000, 32'h108); step();
        fetch(32'h0042_2020, 32'h10C); step();
        fetch(32'h0, 32'h110);
        settle();
        chk("rststall_haz", 32'(hazardDetected), 32'd1);
        rst_n = 1'b0;
        tick();
        settle();
        chk("rststall_ctrl", 32'({RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE}), 32'd0);
        chk("rststall_haz0", 32'(hazardDetected), 32'd0);
        rst_n = 1'b1;
        tick();

        // Random traffic with hazards encouraged by a small register window.
        for (int n = 0; n < 400; n++) begin
            rst_n        = ($urandom_range(0, 39) != 0);
            fetch(rand_instr(), {$urandom} & 32'hFFFF_FFFC);
            RegWriteW    = 1'($urandom);
            WriteRegW    = 5'($urandom_range(0, 7));
            ResultW      = $urandom;
            RegWriteM    = 1'($urandom);
            MemtoRegM    = ($urandom_range(0, 3) == 0);
            WriteRegM    = 5'($urandom_range(0, 7));
            ALUOutM      = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
